// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: command codes and FSM state encoding shared by the loader.
package uart_loader_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  typedef enum logic [2:0] {IDLE, ADLO, ADHI, LEN, WDATA, RREAD, RSEND, SUM} state_e;
endpackage

// File: rtl/uart_timeout.sv
// uart_timeout: counts enabled idle clocks; expired on the TIMEOUT-th clock since the last clear.
module uart_timeout #(
  parameter int TIMEOUT = 2500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (clear_i || !enable_i) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = enable_i && cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/uart_loader.sv
// uart_loader: UART-driven memory loader; 'W'/'R' packets write or read a block
// and answer with an 8-bit additive checksum.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT = 2500000,
  parameter int ADDR_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ready_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_we_o,
  input  logic              tx_ready_i,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [7:0]        mem_out_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_in_i,
  output logic              busy_o
);
  state_e state_q, state_d;
  logic cmd_q, cmd_d, wait_q, wait_d, mwe_q, mwe_d, txwe_q, expired, tmo_en, send;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [7:0] cnt_q, cnt_d, sum_q, sum_d, data_q, data_d, mout_q, mout_d;

  assign tmo_en = state_q inside {ADLO, ADHI, LEN, WDATA};
  uart_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(rx_ready_i), .enable_i(tmo_en), .expired_o(expired)
  );

  // tx_we is combinational so it can never be raised while tx_ready is low.
  assign send          = tx_ready_i && !txwe_q;
  assign tx_data_o     = state_q == SUM ? sum_q : data_q;
  assign mem_address_o = maddr_q;
  assign mem_out_o     = mout_q;
  assign mem_we_o      = mwe_q;
  assign busy_o        = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    maddr_d = maddr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    data_d  = data_q;
    mout_d  = mout_q;
    wait_d  = 1'b0;
    mwe_d   = 1'b0;
    tx_we_o = 1'b0;
    case (state_q)
      IDLE: if (rx_ready_i && (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ)) begin
        cmd_d   = rx_data_i == CMD_WRITE;
        sum_d   = 8'h00;
        state_d = ADLO;
      end
      ADLO: if (rx_ready_i) begin
        addr_d  = ADDR_W'(rx_data_i);
        state_d = ADHI;
      end else if (expired) state_d = IDLE;
      ADHI: if (rx_ready_i) begin
        addr_d[15:8] = rx_data_i;
        state_d      = LEN;
      end else if (expired) state_d = IDLE;
      LEN: if (rx_ready_i) begin
        cnt_d   = rx_data_i;
        maddr_d = addr_q;
        state_d = cmd_q ? WDATA : RREAD;
      end else if (expired) state_d = IDLE;
      WDATA: if (rx_ready_i) begin
        mwe_d   = 1'b1;
        mout_d  = rx_data_i;
        maddr_d = addr_q;
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 8'd1;
        sum_d   = sum_q + rx_data_i;
        state_d = cnt_q == 8'd1 ? SUM : WDATA;
      end else if (expired) state_d = IDLE;
      RREAD: begin
        wait_d = !wait_q;
        if (wait_q) begin
          data_d  = mem_in_i;
          state_d = RSEND;
        end
      end
      RSEND: if (send) begin
        tx_we_o = 1'b1;
        sum_d   = sum_q + data_q;
        addr_d  = addr_q + 1'b1;
        maddr_d = addr_q + 1'b1;
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd1 ? SUM : RREAD;
      end
      SUM: if (send) begin
        tx_we_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      maddr_q <= '0;
      cnt_q   <= 8'h00;
      sum_q   <= 8'h00;
      data_q  <= 8'h00;
      mout_q  <= 8'h00;
      wait_q  <= 1'b0;
      mwe_q   <= 1'b0;
      txwe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      mout_q  <= mout_d;
      wait_q  <= wait_d;
      mwe_q   <= mwe_d;
      txwe_q  <= tx_we_o;
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized packet bench with a byte-level reference model of the loader protocol.
module tb_uart_loader;
  localparam int TMO = 40;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = 8'h00, tx_data, mem_out, mem_in = 8'h00;
  logic rx_ready = 1'b0, tx_ready = 1'b1, tx_we, mem_we, busy;
  logic [15:0] mem_address;
  int tests = 0, fails = 0, viol = 0, gap_fixed = -1;
  bit prev_we = 1'b0, rnd_ready = 1'b0;
  logic [7:0] ram [65536];
  logic [7:0] ref_mem [65536];
  logic [7:0] pkt [256];
  logic [23:0] got_w[$], exp_w[$];
  logic [7:0] got_tx[$], exp_tx[$];

  always #5 clk = ~clk;

  uart_loader #(.TIMEOUT(TMO), .ADDR_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_ready_i(rx_ready),
    .tx_data_o(tx_data), .tx_we_o(tx_we), .tx_ready_i(tx_ready),
    .mem_address_o(mem_address), .mem_out_o(mem_out), .mem_we_o(mem_we),
    .mem_in_i(mem_in), .busy_o(busy)
  );

  // synchronous-read memory attached to the loader
  always @(posedge clk) begin
    if (mem_we) ram[mem_address] <= mem_out;
    mem_in <= ram[mem_address];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) got_w.push_back({mem_address, mem_out});
      if (tx_we) begin
        got_tx.push_back(tx_data);
        if (!tx_ready || prev_we) viol <= viol + 1;
      end
      prev_we <= tx_we;
    end else prev_we <= 1'b0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int gp();
    return gap_fixed >= 0 ? gap_fixed : int'($urandom_range(0, 3));
  endfunction

  task automatic clear_obs();
    got_w.delete();
    got_tx.delete();
    exp_w.delete();
    exp_tx.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 6000);
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s idle: busy still %b after %0d cycles, required 0", name, busy, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string name);
    tests++;
    if (got_w.size() != exp_w.size()) begin
      fails++;
      $display("FAIL %s write count: got %0d required %0d", name, got_w.size(), exp_w.size());
    end else foreach (exp_w[i]) begin
      tests++;
      if (got_w[i] !== exp_w[i]) begin
        fails++;
        $display("FAIL %s write %0d: got addr/data %h required %h", name, i, got_w[i], exp_w[i]);
      end
    end
    tests++;
    if (got_tx.size() != exp_tx.size()) begin
      fails++;
      $display("FAIL %s tx count: got %0d required %0d", name, got_tx.size(), exp_tx.size());
    end else foreach (exp_tx[i]) begin
      tests++;
      if (got_tx[i] !== exp_tx[i]) begin
        fails++;
        $display("FAIL %s tx byte %0d: got %h required %h", name, i, got_tx[i], exp_tx[i]);
      end
    end
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL %s tx handshake violations: got %0d required 0", name, viol);
    end
  endtask

  task automatic run_packet(input string name, input bit is_w, input logic [15:0] a, input int len);
    logic [7:0] s = 8'h00;
    logic [15:0] ad;
    clear_obs();
    for (int i = 0; i < len; i++) begin
      ad = a + 16'(i);
      if (is_w) begin
        exp_w.push_back({ad, pkt[i]});
        ref_mem[ad] = pkt[i];
        s += pkt[i];
      end else begin
        exp_tx.push_back(ref_mem[ad]);
        s += ref_mem[ad];
      end
    end
    exp_tx.push_back(s);
    send_byte(is_w ? 8'h57 : 8'h52, gp());
    send_byte(a[7:0], gp());
    send_byte(a[15:8], gp());
    send_byte(8'(len), gp());
    if (is_w) for (int i = 0; i < len; i++) send_byte(pkt[i], gp());
    wait_idle(name);
    check_obs(name);
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if ({tx_we, mem_we, tx_data, mem_out, mem_address, busy} !== 35'd0) begin
      fails++;
      $display("FAIL %s: got we=%b/%b tx=%h mo=%h addr=%h busy=%b required all zero",
               name, tx_we, mem_we, tx_data, mem_out, mem_address, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_released");
  endtask

  task automatic test_write_basic();
    pkt[0] = 8'hAA; pkt[1] = 8'hBB; pkt[2] = 8'hCC;
    run_packet("write_basic", 1'b1, 16'h1000, 3);
    tests++;
    if (exp_tx[0] !== 8'h31 || got_tx.size() != 1 || got_tx[0] !== 8'h31) begin
      fails++;
      $display("FAIL write_basic checksum: got %0d bytes, required single byte 31", got_tx.size());
    end
  endtask

  task automatic test_read();
    rnd_ready = 1'b1;
    run_packet("read_basic", 1'b0, 16'h2000, 2);
  endtask

  task automatic test_wrap();
    pkt[0] = 8'h01; pkt[1] = 8'h02;
    run_packet("addr_wrap", 1'b1, 16'hFFFF, 2);
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, TMO);
    tests++;
    if (busy !== 1'b0 || got_w.size() != 0 || got_tx.size() != 0) begin
      fails++;
      $display("FAIL timeout_drop: got busy=%b writes=%0d tx=%0d required 0/0/0", busy, got_w.size(), got_tx.size());
    end
    run_packet("after_timeout", 1'b0, 16'h2000, 1);
    gap_fixed = TMO - 1;
    pkt[0] = 8'h5A; pkt[1] = 8'hC3;
    run_packet("rx_beats_timeout", 1'b1, 16'h3000, 2);
    gap_fixed = -1;
  endtask

  task automatic test_len256();
    send_byte(8'h41, 2);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_byte: got busy=%b required 0", busy);
    end
    for (int i = 0; i < 256; i++) pkt[i] = 8'($urandom);
    run_packet("len256", 1'b1, 16'($urandom), 256);
  endtask

  task automatic test_reset_mid();
    clear_obs();
    pkt[0] = 8'h9D; pkt[1] = 8'h4E;
    send_byte(8'h57, gp());
    send_byte(8'h00, gp());
    send_byte(8'h40, gp());
    send_byte(8'h04, gp());
    send_byte(pkt[0], gp());
    send_byte(pkt[1], 1);
    ref_mem[16'h4000] = pkt[0];
    ref_mem[16'h4001] = pkt[1];
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    tests++;
    if (got_w.size() != 2) begin
      fails++;
      $display("FAIL reset_mid partial writes: got %0d required 2", got_w.size());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pkt[i] = 8'($urandom);
    run_packet("after_reset_write", 1'b1, 16'h5000, 4);
    run_packet("after_reset_read", 1'b0, 16'h4000, 4);
  endtask

  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      int len = int'($urandom_range(1, 8));
      logic [15:0] a = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom_range(0, 63)) + 16'h6000;
      for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
      run_packet("random", $urandom_range(0, 1) == 1, a, len);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16'h2000] = 8'h11; ref_mem[16'h2000] = 8'h11;
    ram[16'h2001] = 8'h22; ref_mem[16'h2001] = 8'h22;
    @(posedge clk);
    #1;
    test_reset();
    test_write_basic();
    test_read();
    test_wrap();
    test_timeout();
    test_len256();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
